// File: rtl/down_timer.sv
// Loadable down-counter with valid/ready load, pause, stop and optional auto-reload.
// Optional feature: define DOWN_TIMER_EXPIRE_CNT_EN to add a saturating expiry counter output.
module down_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             auto_reload,
   input  logic             pause,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             busy,
`ifdef DOWN_TIMER_EXPIRE_CNT_EN
   output logic [7:0]       expire_cnt,
`endif
   output logic             done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] reloadVal_q;
   logic             autoFlag_q;
   logic             done_q;
`ifdef DOWN_TIMER_EXPIRE_CNT_EN
   logic [7:0]       expireCnt_q;
`endif

   assign load_ready = (state_q == IDLE) && !stop && !rst;
   assign count      = count_q;
   assign busy       = (state_q == RUN);
   assign done       = done_q;
`ifdef DOWN_TIMER_EXPIRE_CNT_EN
   assign expire_cnt = expireCnt_q;
`endif

   // Priority per edge: rst, then stop, then load accept, then decrement.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         reloadVal_q <= '0;
         autoFlag_q  <= 1'b0;
         done_q      <= 1'b0;
`ifdef DOWN_TIMER_EXPIRE_CNT_EN
         expireCnt_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (stop) begin
            state_q <= IDLE;
            count_q <= '0;
         end else if (state_q == IDLE) begin
            if (load_valid) begin
               if (load_value != '0) begin
                  state_q     <= RUN;
                  count_q     <= load_value;
                  reloadVal_q <= load_value;
                  autoFlag_q  <= auto_reload;
               end else begin
                  // Zero-length timer expires on the accepting edge.
                  count_q <= '0;
                  done_q  <= 1'b1;
`ifdef DOWN_TIMER_EXPIRE_CNT_EN
                  if (expireCnt_q != 8'hFF) expireCnt_q <= expireCnt_q + 8'd1;
`endif
               end
            end
         end else if (!pause) begin
            if (count_q > WIDTH'(1)) begin
               count_q <= count_q - WIDTH'(1);
            end else begin
               done_q <= 1'b1;
`ifdef DOWN_TIMER_EXPIRE_CNT_EN
               if (expireCnt_q != 8'hFF) expireCnt_q <= expireCnt_q + 8'd1;
`endif
               if (autoFlag_q) begin
                  count_q <= reloadVal_q;
               end else begin
                  count_q <= '0;
                  state_q <= IDLE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios followed by random traffic,
// all compared against an integer reference model of the timer's rules.
module tb_down_timer;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_value;
   logic             auto_reload;
   logic             pause;
   logic             stop;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
`ifdef DOWN_TIMER_EXPIRE_CNT_EN
   logic [7:0]       expire_cnt;
`endif

   int compareCnt = 0;
   int failCnt    = 0;

   // Reference model state: plain integers describing the timer's contract.
   int mCount, mReload, mExp;
   bit mRun, mAuto, mDone;

   down_timer #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_value  (load_value),
      .auto_reload (auto_reload),
      .pause       (pause),
      .stop        (stop),
      .count       (count),
      .busy        (busy),
`ifdef DOWN_TIMER_EXPIRE_CNT_EN
      .expire_cnt  (expire_cnt),
`endif
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compareCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelStep(input bit r, input bit st, input bit lv, input int lval,
                            input bit ar, input bit pa);
      if (r) begin
         mCount = 0; mRun = 0; mDone = 0; mReload = 0; mAuto = 0; mExp = 0;
      end else begin
         mDone = 0;
         if (st) begin
            mRun = 0;
            mCount = 0;
         end else if (!mRun) begin
            if (lv) begin
               if (lval == 0) mDone = 1;
               else begin
                  mRun = 1; mCount = lval; mReload = lval; mAuto = ar;
               end
            end
         end else if (!pa) begin
            mCount = mCount - 1;
            if (mCount == 0) begin
               mDone = 1;
               if (mAuto) mCount = mReload;
               else mRun = 0;
            end
         end
         if (mDone && mExp < 255) mExp = mExp + 1;
      end
   endtask

   // One clock: drive inputs, check the combinational ready, clock, then check registered outputs.
   task automatic applyStimulus(input bit r, input bit st, input bit lv, input int lval,
                                input bit ar, input bit pa);
      rst = r; stop = st; load_valid = lv; load_value = WIDTH'(lval);
      auto_reload = ar; pause = pa;
      #1;
      checkOutput("load_ready", {31'd0, load_ready}, {31'd0, (!mRun && !st && !r)});
      @(posedge clk);
      modelStep(r, st, lv, lval, ar, pa);
      #1;
      checkOutput("count", {24'd0, count}, mCount);
      checkOutput("busy",  {31'd0, busy},  {31'd0, mRun});
      checkOutput("done",  {31'd0, done},  {31'd0, mDone});
`ifdef DOWN_TIMER_EXPIRE_CNT_EN
      checkOutput("expire_cnt", {24'd0, expire_cnt}, mExp);
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      $display("[TB] down_timer bench starting");
      mCount = 0; mReload = 0; mExp = 0; mRun = 0; mAuto = 0; mDone = 0;
      @(posedge clk); #1;

      // Reset state
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 5, 0, 0);
      checkOutput("reset_count", {24'd0, count}, 0);

      // One-shot N=5: 5,4,3,2,1 then expiry
      applyStimulus(0, 0, 1, 5, 0, 0);
      checkOutput("oneshot_start", {24'd0, count}, 5);
      idle(4);
      checkOutput("oneshot_last", {24'd0, count}, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("oneshot_done", {31'd0, done}, 1);
      checkOutput("oneshot_busy", {31'd0, busy}, 0);
      idle(2);

      // Auto-reload N=3 for 10 cycles
      applyStimulus(0, 0, 1, 3, 1, 0);
      idle(10);
      checkOutput("auto_busy", {31'd0, busy}, 1);

      // Stop at count 3 with a simultaneous load request
      while (count != 3) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 6, 0, 0);
      checkOutput("stop_count", {24'd0, count}, 0);
      checkOutput("stop_busy", {31'd0, busy}, 0);
      idle(1);

      // N=4 with pause held for two cycles at count 2
      applyStimulus(0, 0, 1, 4, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("pause_hold", {24'd0, count}, 2);
      idle(3);

      // Zero-length load
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("zero_done", {31'd0, done}, 1);
      idle(1);

      // Full-scale load, reset mid-run at count 7
      applyStimulus(0, 0, 1, 255, 0, 0);
      while (count != 7) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("midrun_reset", {24'd0, count}, 0);

`ifdef DOWN_TIMER_EXPIRE_CNT_EN
      // Saturate the expiry counter with zero-loads, then reset it
      for (int i = 0; i < 300; i++) applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("expcnt_sat", {24'd0, expire_cnt}, 255);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("expcnt_reset", {24'd0, expire_cnt}, 0);
`endif

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         int  lval;
         lval = ($urandom_range(0, 49) == 0) ? 255 : int'($urandom_range(0, 7));
         applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
                       $urandom_range(0, 1) == 1, lval, $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 4) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
      $finish;
   end

endmodule
